factor_packer: RTL and testbench

- Sits directly downstream of the prime-factorisation stage and consumes its length-prefixed factor stream: one length word N, then N factor words on consecutive cycles, largest factor first.
- Run-length compresses the stream into (prime, exponent) pairs.
- Writes the result to the output FIFO as a pair-count word followed by the pairs, respecting FIFO full backpressure.
- The upstream stage cannot be stalled, so a whole frame is buffered internally before output starts.

---
 rtl/factor_packer.sv | 160 ++++++++++++++++
 tb/tb_factor_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/factor_packer.sv
// Run-length packs a length-prefixed factor stream into (prime, exponent) pairs behind a pair-count word.
// Define FACTOR_PACKER_PRODUCT_EN to append the product of the accepted factors as a trailer word.
module factor_packer #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int MAX_FACTORS      = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RAH_PACKET_WIDTH-1:0] in_data,
  input  logic                        in_wren,
  input  logic                        out_full,
  output logic [RAH_PACKET_WIDTH-1:0] out_data,
  output logic                        out_wren,
  output logic                        err
);
  localparam int W  = RAH_PACKET_WIDTH;
  localparam int CW = $clog2(MAX_FACTORS + 1);

`ifdef FACTOR_PACKER_PRODUCT_EN
  typedef enum logic [2:0] {IDLE, RECV, DRAIN, EMIT_CNT, EMIT_PRIME, EMIT_EXP, EMIT_PROD} state_t;
  localparam state_t AFTER_PAIRS = EMIT_PROD;
`else
  typedef enum logic [2:0] {IDLE, RECV, DRAIN, EMIT_CNT, EMIT_PRIME, EMIT_EXP} state_t;
  localparam state_t AFTER_PAIRS = IDLE;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, rem, idx;
  logic [CW-1:0] cnt_m1;
  logic [W-1:0]  prime_mem [MAX_FACTORS];
  logic [W-1:0]  exp_mem   [MAX_FACTORS];
  logic [W-1:0]  data_n;
  logic          wren_n, err_n, match;
`ifdef FACTOR_PACKER_PRODUCT_EN
  logic [W-1:0]  prod;
`endif

  assign cnt_m1 = cnt - CW'(1);
  // Runs of equal primes arrive contiguously, so only the newest pair can extend.
  assign match  = (cnt != '0) && (in_data == prime_mem[cnt_m1]);

  always_comb begin
    state_n = state;
    data_n  = out_data;
    wren_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (in_wren) begin
          if (in_data > W'(MAX_FACTORS)) begin
            err_n   = 1'b1;
            state_n = DRAIN;
          end else if (in_data == '0) begin
            state_n = EMIT_CNT;
          end else begin
            state_n = RECV;
          end
        end
      end
      RECV: begin
        if (!in_wren) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (rem == CW'(1)) begin
          state_n = EMIT_CNT;
        end
      end
      DRAIN: begin
        if (in_wren) err_n = 1'b1;
        else         state_n = IDLE;
      end
      EMIT_CNT: begin
        err_n = in_wren;
        if (!out_full) begin
          wren_n  = 1'b1;
          data_n  = W'(cnt);
          state_n = (cnt == '0) ? AFTER_PAIRS : EMIT_PRIME;
        end
      end
      EMIT_PRIME: begin
        err_n = in_wren;
        if (!out_full) begin
          wren_n  = 1'b1;
          data_n  = prime_mem[idx];
          state_n = EMIT_EXP;
        end
      end
      EMIT_EXP: begin
        err_n = in_wren;
        if (!out_full) begin
          wren_n  = 1'b1;
          data_n  = exp_mem[idx];
          state_n = (idx == cnt_m1) ? AFTER_PAIRS : EMIT_PRIME;
        end
      end
`ifdef FACTOR_PACKER_PRODUCT_EN
      EMIT_PROD: begin
        err_n = in_wren;
        if (!out_full) begin
          wren_n  = 1'b1;
          data_n  = prod;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_data <= '0;
      out_wren <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      idx      <= '0;
    end else begin
      state    <= state_n;
      out_data <= data_n;
      out_wren <= wren_n;
      err      <= err_n;
      case (state)
        IDLE: if (in_wren) begin
          rem <= in_data[CW-1:0];
          cnt <= '0;
        end
        RECV: if (in_wren) begin
          rem <= rem - CW'(1);
          if (!match) cnt <= cnt + CW'(1);
        end
        EMIT_CNT: idx <= '0;
        EMIT_EXP: if (!out_full) idx <= idx + CW'(1);
        default: ;
      endcase
    end
  end

  // Pair storage
  always_ff @(posedge clk) begin
    if (state == RECV && in_wren) begin
      if (match) begin
        exp_mem[cnt_m1] <= exp_mem[cnt_m1] + W'(1);
      end else begin
        prime_mem[cnt] <= in_data;
        exp_mem[cnt]   <= W'(1);
      end
    end
  end

`ifdef FACTOR_PACKER_PRODUCT_EN
  always_ff @(posedge clk) begin
    if (state == IDLE && in_wren) prod <= W'(1);
    else if (state == RECV && in_wren) prod <= prod * in_data;
  end
`endif

endmodule

// File: tb/tb_factor_packer.sv
// Directed bench for factor_packer: frame table with out_full=0 plus hand-written backpressure,
// truncation, emit-time input and mid-emit reset sequences.
module tb_factor_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] in_data;
  logic        in_wren;
  logic        out_full;
  logic [47:0] out_data;
  logic        out_wren;
  logic        err;

  factor_packer #(.RAH_PACKET_WIDTH(48), .MAX_FACTORS(24)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wren(in_wren),
    .out_full(out_full), .out_data(out_data), .out_wren(out_wren), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nin;
    logic [47:0] din [26];
    int          nout;
    logic [47:0] dout [8];
    int          nerr;
  } vec_t;

  vec_t        tbl [8];
  int          ntbl = 0;
  logic [47:0] sin[$], sout[$], want[$], got[$];
  int          got_cyc[$];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, last_cyc = 0, errs = 0;
  logic        prev_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_wren === 1'b1) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
      check("write_while_full", {63'd0, prev_full}, 64'd0);
    end
    if (err === 1'b1) errs++;
    prev_full = out_full;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] w);
    in_wren  = 1'b1;
    in_data  = w;
    last_cyc = cyc;
    tick();
  endtask

  task automatic clear();
    got.delete();
    got_cyc.delete();
    want.delete();
    errs = 0;
  endtask

  task automatic check_words(input string name, input int exp_err);
    check({name, "_count"}, got.size(), want.size());
    for (int k = 0; k < got.size() && k < want.size(); k++)
      check($sformatf("%s_word%0d", name, k), got[k], want[k]);
    check({name, "_err"}, errs, exp_err);
  endtask

  task automatic add_vec(input int nerr, input logic [47:0] prod);
`ifdef FACTOR_PACKER_PRODUCT_EN
    if (sout.size() != 0) sout.push_back(prod);
`else
    if (prod == 48'd0) sout = sout;
`endif
    tbl[ntbl].nin = sin.size();
    for (int j = 0; j < 26; j++) tbl[ntbl].din[j] = (j < sin.size()) ? sin[j] : 48'd0;
    tbl[ntbl].nout = sout.size();
    for (int j = 0; j < 8; j++) tbl[ntbl].dout[j] = (j < sout.size()) ? sout[j] : 48'd0;
    tbl[ntbl].nerr = nerr;
    ntbl++;
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    clear();
    for (int j = 0; j < tbl[i].nin; j++) send(tbl[i].din[j]);
    in_wren = 1'b0;
    repeat (tbl[i].nout + 6) tick();
    for (int j = 0; j < tbl[i].nout; j++) want.push_back(tbl[i].dout[j]);
    check_words(nm, tbl[i].nerr);
    if (tbl[i].nout > 0 && got.size() == tbl[i].nout) begin
      check({nm, "_latency"}, got_cyc[0] - last_cyc, 2);
      for (int j = 1; j < got.size(); j++)
        check($sformatf("%s_gap%0d", nm, j), got_cyc[j] - got_cyc[j-1], 1);
    end
  endtask

  initial begin
    logic [4:0] pat;
    rst = 1'b1; in_wren = 1'b0; in_data = '0; out_full = 1'b0;
    repeat (3) tick();
    check("rst_out_data", out_data, 0);
    check("rst_out_wren", out_wren, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    sin = '{6, 5, 3, 3, 2, 2, 2}; sout = '{3, 5, 1, 3, 2, 2, 3}; add_vec(0, 360);
    sin = '{0};                   sout = '{0};                   add_vec(0, 1);
    sin = '{3, 11, 7, 7};         sout = '{2, 11, 1, 7, 2};      add_vec(0, 539);
    sin = '{24};                  for (int j = 0; j < 24; j++) sin.push_back(2);
    sout = '{1, 2, 24};                                          add_vec(0, 48'd16777216);
    sin = '{25};                  for (int j = 0; j < 25; j++) sin.push_back(3);
    sout.delete();                                               add_vec(26, 0);
    sin = '{1, 7};                sout = '{1, 7, 1};             add_vec(0, 7);
    for (int i = 0; i < ntbl; i++) run_vec(i);

    // Backpressure toggling 1,0,1,1,0...
    clear();
    pat = 5'b01101;
    out_full = 1'b1;
    send(2); send(13); send(13);
    in_wren = 1'b0;
    for (int i = 0; i < 25; i++) begin
      out_full = pat[i % 5];
      tick();
    end
    out_full = 1'b0;
    repeat (4) tick();
    want = '{1, 13, 2};
`ifdef FACTOR_PACKER_PRODUCT_EN
    want.push_back(169);
`endif
    check_words("toggle_full", 0);

    // Truncated frame
    clear();
    send(4); send(3); send(3);
    in_wren = 1'b0;
    repeat (5) tick();
    check_words("truncated", 1);

    // New frame arriving while emitting is dropped
    clear();
    out_full = 1'b1;
    send(1); send(5);
    in_wren = 1'b0;
    tick();
    send(2); send(3); send(3);
    in_wren = 1'b0;
    repeat (3) tick();
    out_full = 1'b0;
    repeat (8) tick();
    want = '{1, 5, 1};
`ifdef FACTOR_PACKER_PRODUCT_EN
    want.push_back(5);
`endif
    check_words("emit_drop", 3);

    // Reset while in EMIT_EXP
    clear();
    send(2); send(13); send(17);
    in_wren = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_wren", out_wren, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_err", err, 0);
    rst = 1'b0;
    repeat (6) tick();
    want = '{2, 13};
    check_words("midrst", 0);

    clear();
    send(1); send(11);
    in_wren = 1'b0;
    repeat (8) tick();
    want = '{1, 11, 1};
`ifdef FACTOR_PACKER_PRODUCT_EN
    want.push_back(11);
`endif
    check_words("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
